rv_multicycle_ctrl: RTL
=======================

// Module: rv_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core. Sequences alu, register file and memories per instruction:
//  FETCH -> DECODE -> EXEC -> [MEM] -> WB. Owns PC, instruction register, immediate generation, PC-update.
//  Sits between IMem/DMem handshakes and the combinational alu/regfile datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  XLEN       32             datapath width (only 32 supported)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous, active-high reset
//  imem_req      out  1   instruction fetch request, held until imem_ack
//  imem_addr     out  32  fetch address (= pc)
//  imem_ack      in   1   fetch done; imem_rdata valid this cycle
//  imem_rdata    in   32  instruction word
//  dmem_req      out  1   data access request, held until dmem_ack
//  dmem_we       out  1   1 = store, 0 = load
//  dmem_ack      in   1   data access done
//  alu_opcode    out  5   instr[6:2] to alu
//  alu_funct3    out  3   instr[14:12]
//  alu_funct7    out  7   instr[31:25]
//  alu_imm       out  32  decoded immediate
//  alu_pc        out  32  pc of current instruction
//  taken_branch  in   1   from alu
//  is_jal        in   1   from alu
//  is_jalr       in   1   from alu
//  rs1_data      in   32  regfile read port A (for jalr target)
//  rf_rs1, rf_rs2 out 5   instr[19:15], instr[24:20]
//  rf_rd         out  5   instr[11:7]
//  rf_we         out  1   regfile write strobe, 1 cycle in WB
//  rf_wd_sel     out  2   0 = alu_out, 1 = pc+4, 2 = dmem rdata
//  illegal       out  1   sticky; set on unsupported opcode
//  retire        out  1   1-cycle pulse when instruction completes
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (nop), all strobes/req=0, illegal=0.
//  FETCH: imem_req=1; on imem_ack latch ir<=imem_rdata -> DECODE. No ack: stay, req held.
//  DECODE: 1 cycle. Imm by instr[6:2]: I (00000,00100,11001), S (01000), B (11000), U (01101,00101), J (11011).
//   Opcode 11001 (JALR) presented to alu as 11011 with funct3=000; JAL as 11011, funct3 forced 3'b001.
//   Any other opcode or instr[1:0]!=2'b11: illegal<=1, state -> HALT (no write, no retire).
//  EXEC: 1 cycle; alu outputs sampled. LOAD/STORE -> MEM; all others -> WB.
//  MEM: dmem_req=1, dmem_we=(opcode==STORE); wait for dmem_ack -> WB.
//  WB: rf_we=1 unless opcode in {BRANCH, STORE} or rf_rd==0; retire=1; pc update; -> FETCH.
//   rf_wd_sel: JAL/JALR=1, LOAD=2, else 0.
//   next pc: is_jal -> pc+imm_J; is_jalr -> (rs1_data+imm_I)&~32'h1; taken_branch -> pc+imm_B; else pc+4.
//   All pc arithmetic modulo 2^32 (wrap at 32'hFFFF_FFFC+4 -> 0).
//  HALT: terminal; only rst exits. Outputs strobes 0.
//  Latency: 4 cycles ALU/branch/jump, 5+ for load/store, plus IMem/DMem wait cycles.
//  rst mid-operation (incl. during a pending req) wins: next cycle in reset state, req dropped, no write.
//  imem_ack outside FETCH / dmem_ack outside MEM: ignored.
//  Outputs rf_we, retire, imem_req, dmem_req are registered-state decodes (glitch-free, no comb. ack path).
// STRUCTURE
//  Shared package rv_pkg: opcode localparams (OP_LUI..OP_OP, OP_JALR_RAW=5'b11001), state encoding
//   (FETCH, DECODE, EXEC, MEM, WB, HALT), rf_wd_sel codes.
//  One sub-module: rv_imm_gen (comb.; ir -> 32-bit immediate by format).
// TESTING
//  rst, then addi x1,x0,5 (32'h0050_0093), imem_ack 1 cycle -> rf_we=1, rf_rd=1, alu_imm=5, pc=4, retire after 4 cycles.
//  beq with taken_branch=1, imm_B=-8 at pc=0x10 -> next imem_addr=0x08; taken_branch=0 -> 0x14; no rf_we.
//  jalr (0x0000_80E7 family) with rs1_data=0x101, imm=0 -> imem_addr=0x100, rf_wd_sel=1, rf_we=1.
//  sw with dmem_ack delayed 3 cycles -> dmem_req/dmem_we held 4 cycles, rf_we=0, retire once.
//  instr 32'hFFFF_FFFF -> illegal=1, HALT; further imem_ack ignored; rst returns pc=RESET_PC, illegal=0.
//  rst asserted during MEM wait -> next cycle dmem_req=0, state FETCH, pc=RESET_PC, no retire.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes (instr[6:2]),
// sequencer states, write-back source codes and immediate format lookup.
package rv_pkg;

   localparam logic [4:0] OP_LOAD     = 5'b00000;
   localparam logic [4:0] OP_OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_AUIPC    = 5'b00101;
   localparam logic [4:0] OP_STORE    = 5'b01000;
   localparam logic [4:0] OP_OP       = 5'b01100;
   localparam logic [4:0] OP_LUI      = 5'b01101;
   localparam logic [4:0] OP_BRANCH   = 5'b11000;
   localparam logic [4:0] OP_JALR_RAW = 5'b11001;
   localparam logic [4:0] OP_JAL      = 5'b11011;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_PC4 = 2'd1;
   localparam logic [1:0] WD_MEM = 2'd2;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_BAD = 3'd6
   } imm_fmt_t;

   // Immediate layout for each supported opcode; anything else is unsupported.
   function automatic imm_fmt_t imm_fmt(input logic [4:0] op);
      imm_fmt_t fmt;
      case (op)
         OP_LOAD, OP_OP_IMM, OP_JALR_RAW: fmt = FMT_I;
         OP_STORE:                        fmt = FMT_S;
         OP_BRANCH:                       fmt = FMT_B;
         OP_LUI, OP_AUIPC:                fmt = FMT_U;
         OP_JAL:                          fmt = FMT_J;
         OP_OP:                           fmt = FMT_R;
         default:                         fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the immediate of
// the instruction word by format and flags encodings the sequencer cannot run.
module rv_imm_gen
   import rv_pkg::*;
(
   input  logic [31:0] ir,
   output logic [31:0] imm,
   output logic        legal
);

   // Pick the immediate layout from the opcode; R-type carries no immediate.
   always_comb begin
      imm   = 32'h0000_0000;
      legal = 1'b0;
      if (ir[1:0] == 2'b11) begin
         legal = 1'b1;
      end else begin
         legal = 1'b0;
      end
      case (imm_fmt(ir[6:2]))
         FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
         FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         FMT_U:   imm = {ir[31:12], 12'h000};
         FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         FMT_R:   imm = 32'h0000_0000;
         default: begin
            imm   = 32'h0000_0000;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Owns pc, instruction register and pc update; the request/strobe outputs are
// decodes of the registered state so no acknowledge reaches them combinationally.
module rv_multicycle_ctrl
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic [4:0]      alu_opcode,
   output logic [2:0]      alu_funct3,
   output logic [6:0]      alu_funct7,
   output logic [XLEN-1:0] alu_imm,
   output logic [XLEN-1:0] alu_pc,
   input  logic            taken_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [XLEN-1:0] rs1_data,
   output logic [4:0]      rf_rs1,
   output logic [4:0]      rf_rs2,
   output logic [4:0]      rf_rd,
   output logic            rf_we,
   output logic [1:0]      rf_wd_sel,
   output logic            illegal,
   output logic            retire
);

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [31:0]     ir_r;
   logic [4:0]      op_raw_r;
   logic [4:0]      alu_opcode_r;
   logic [2:0]      alu_funct3_r;
   logic [XLEN-1:0] alu_imm_r;
   logic [1:0]      rf_wd_sel_r;
   logic            wb_write_r;
   logic [XLEN-1:0] next_pc_r;
   logic            illegal_r;

   logic [4:0]      op_s;
   logic [31:0]     imm_s;
   logic            legal_s;
   logic [4:0]      dec_opcode_s;
   logic [2:0]      dec_funct3_s;
   logic [1:0]      dec_wd_sel_s;
   logic            dec_wb_write_s;
   logic [XLEN-1:0] target_s;

   assign op_s = ir_r[6:2];

   rv_imm_gen u_imm_gen (
      .ir    (ir_r),
      .imm   (imm_s),
      .legal (legal_s)
   );

   // Translate the raw opcode into what the alu sees and how write-back behaves.
   always_comb begin
      dec_opcode_s   = op_s;
      dec_funct3_s   = ir_r[14:12];
      dec_wd_sel_s   = WD_ALU;
      dec_wb_write_s = (ir_r[11:7] != 5'd0);
      case (op_s)
         OP_JAL: begin
            dec_opcode_s = OP_JAL;
            dec_funct3_s = 3'b001;
            dec_wd_sel_s = WD_PC4;
         end
         OP_JALR_RAW: begin
            dec_opcode_s = OP_JAL;
            dec_funct3_s = 3'b000;
            dec_wd_sel_s = WD_PC4;
         end
         OP_LOAD: begin
            dec_wd_sel_s = WD_MEM;
         end
         OP_BRANCH, OP_STORE: begin
            dec_wb_write_s = 1'b0;
         end
         default: begin
            dec_wd_sel_s = WD_ALU;
         end
      endcase
   end

   // Next-pc candidate from the alu verdicts; 32-bit adds wrap naturally.
   always_comb begin
      if (is_jal) begin
         target_s = pc_r + alu_imm_r;
      end else if (is_jalr) begin
         target_s = (rs1_data + alu_imm_r) & 32'hFFFF_FFFE;
      end else if (taken_branch) begin
         target_s = pc_r + alu_imm_r;
      end else begin
         target_s = pc_r + 32'd4;
      end
   end

   // Sequencer state, pc, instruction register and decoded fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= FETCH;
         pc_r         <= RESET_PC;
         ir_r         <= NOP_INSTR;
         op_raw_r     <= OP_OP_IMM;
         alu_opcode_r <= OP_OP_IMM;
         alu_funct3_r <= 3'b000;
         alu_imm_r    <= 32'h0000_0000;
         rf_wd_sel_r  <= WD_ALU;
         wb_write_r   <= 1'b0;
         next_pc_r    <= RESET_PC;
         illegal_r    <= 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               if (imem_ack) begin
                  ir_r    <= imem_rdata;
                  state_r <= DECODE;
               end
            end
            DECODE: begin
               if (!legal_s) begin
                  illegal_r <= 1'b1;
                  state_r   <= HALT;
               end else begin
                  op_raw_r     <= op_s;
                  alu_opcode_r <= dec_opcode_s;
                  alu_funct3_r <= dec_funct3_s;
                  alu_imm_r    <= imm_s;
                  rf_wd_sel_r  <= dec_wd_sel_s;
                  wb_write_r   <= dec_wb_write_s;
                  state_r      <= EXEC;
               end
            end
            EXEC: begin
               next_pc_r <= target_s;
               if ((op_raw_r == OP_LOAD) || (op_raw_r == OP_STORE)) begin
                  state_r <= MEM;
               end else begin
                  state_r <= WB;
               end
            end
            MEM: begin
               if (dmem_ack) begin
                  state_r <= WB;
               end
            end
            WB: begin
               pc_r    <= next_pc_r;
               state_r <= FETCH;
            end
            HALT: begin
               state_r <= HALT;
            end
            default: begin
               state_r <= HALT;
            end
         endcase
      end
   end

   assign imem_req   = (state_r == FETCH);
   assign imem_addr  = pc_r;
   assign dmem_req   = (state_r == MEM);
   assign dmem_we    = (state_r == MEM) && (op_raw_r == OP_STORE);
   assign alu_opcode = alu_opcode_r;
   assign alu_funct3 = alu_funct3_r;
   assign alu_funct7 = ir_r[31:25];
   assign alu_imm    = alu_imm_r;
   assign alu_pc     = pc_r;
   assign rf_rs1     = ir_r[19:15];
   assign rf_rs2     = ir_r[24:20];
   assign rf_rd      = ir_r[11:7];
   assign rf_we      = (state_r == WB) && wb_write_r;
   assign rf_wd_sel  = rf_wd_sel_r;
   assign illegal    = illegal_r;
   assign retire     = (state_r == WB);

endmodule
